// File: rtl/jit_cmd_master_if.sv
// Purpose : one valid/ready stream hop (valid, ready, 32-bit data) for the command ring master.
// Latency : none, this is wiring only.
// Backpr. : ready flows from slave to master, and a beat moves when valid && ready.
//
// Ports (modports):
//   master : drives tvalid/tdata, samples tready
//   slave  : samples tvalid/tdata, drives tready
interface jit_cmd_master_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/jit_cmd_master.sv
// Purpose : ring command master. It injects one host command onto the ring, waits for it to return, and reports the result.
// Latency : at least 4 cycles from host handshake back to IDLE (IDLE, SEND, WAIT, REPORT).
// Backpr. : the host and ring egress stall on their readies, the status is held until accepted, and ring ingress is never stalled.
//
// Ports:
//   ACLK, ARESETN   clock (rising edge), async active-low reset
//   sH  (slave)     host command stream in
//   mR  (master)    ring egress, to the first jit_cmd stage
//   sR  (slave)     ring ingress, from the last jit_cmd stage
//   mS  (master)    status stream out: [31:30] code, [27:16] cmd[11:0], [15:0] latency
//   BUSY            high whenever the FSM is not IDLE
//   STALE_CNT       saturating count of ring beats seen outside WAIT
module jit_cmd_master #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    jit_cmd_master_if.slave        sH,
    jit_cmd_master_if.master       mR,
    jit_cmd_master_if.slave        sR,
    jit_cmd_master_if.master       mS,
    output logic                   BUSY,
    output logic [7:0]             STALE_CNT
);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SEND   = 4'b0010,
        WAIT   = 4'b0100,
        REPORT = 4'b1000
    } state_t;

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_NOKEY   = 2'b01;
    localparam logic [1:0] CODE_BADRESP = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] LAT_TO   = 16'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cmd;
    logic [15:0] lat_cnt;
    logic [31:0] status;
    logic [7:0]  stale_cnt;

    logic        report_en;
    logic [1:0]  code_nxt;
    logic [15:0] lat_nxt;

    // Next-state logic and the classification of the returning word.
    always_comb begin
        state_nxt = state;
        report_en = 1'b0;
        code_nxt  = CODE_OK;
        lat_nxt   = lat_cnt;
        case (state)
            IDLE: begin
                if (sH.tvalid) state_nxt = SEND;
            end
            SEND: begin
                if (mR.tready) state_nxt = WAIT;
            end
            WAIT: begin
                // A beat on the same cycle as the last count wins over the timeout.
                if (sR.tvalid) begin
                    state_nxt = REPORT;
                    report_en = 1'b1;
                    if (sR.tdata == {28'd0, cmd[11:8]})
                        code_nxt = CODE_OK;
                    else if (sR.tdata == cmd)
                        code_nxt = CODE_NOKEY;
                    else
                        code_nxt = CODE_BADRESP;
                end else if (lat_cnt == CNT_LAST) begin
                    state_nxt = REPORT;
                    report_en = 1'b1;
                    code_nxt  = CODE_TIMEOUT;
                    lat_nxt   = LAT_TO;
                end
            end
            REPORT: begin
                if (mS.tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cmd       <= '0;
            lat_cnt   <= '0;
            status    <= '0;
            stale_cnt <= '0;
        end else begin
            if (state == IDLE && sH.tvalid)
                cmd <= sH.tdata;

            if (state == SEND && mR.tready)
                lat_cnt <= '0;
            else if (state == WAIT && !report_en)
                lat_cnt <= lat_cnt + 16'd1;

            if (report_en)
                status <= {code_nxt, 2'b00, cmd[11:0], lat_nxt};

            // Ingress is always ready, so any beat outside WAIT is dropped here.
            // This includes late answers to commands that already timed out.
            if (sR.tvalid && state != WAIT && stale_cnt != 8'hFF)
                stale_cnt <= stale_cnt + 8'd1;
        end
    end

    assign sH.tready = (state == IDLE);
    assign mR.tvalid = (state == SEND);
    assign mR.tdata  = (state == SEND) ? cmd : 32'd0;
    assign sR.tready = ARESETN;
    assign mS.tvalid = (state == REPORT);
    assign mS.tdata  = status;
    assign BUSY      = (state != IDLE);
    assign STALE_CNT = stale_cnt;

endmodule

// File: tb/tb_jit_cmd_master.sv
// Purpose : directed self-checking bench for jit_cmd_master with TIMEOUT=16.
// Latency : inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : the bench drives mR/mS readies directly to exercise the stalls.
module tb_jit_cmd_master;

    logic       ACLK;
    logic       ARESETN;
    logic       BUSY;
    logic [7:0] STALE_CNT;

    jit_cmd_master_if sH();
    jit_cmd_master_if mR();
    jit_cmd_master_if sR();
    jit_cmd_master_if mS();

    jit_cmd_master #(.TIMEOUT(16)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .sH        (sH),
        .mR        (mR),
        .sR        (sR),
        .mS        (mS),
        .BUSY      (BUSY),
        .STALE_CNT (STALE_CNT)
    );

    int n_checks   = 0;
    int n_errors   = 0;
    int n_status   = 0;
    int exp_status = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Count status words that the sink actually accepts.
    always @(posedge ACLK) begin
        if (ARESETN && mS.tvalid && mS.tready) n_status <= n_status + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Handshake a command, let it be accepted on the ring, and leave the DUT in its first WAIT cycle.
    task automatic enter_wait(input logic [31:0] c);
        sH.tvalid = 1'b1;
        sH.tdata  = c;
        chk("idle_sh_rdy", 32'(sH.tready), 32'd1);
        tick();
        sH.tvalid = 1'b0;
        sH.tdata  = 32'd0;
        chk("send_vld", 32'(mR.tvalid), 32'd1);
        chk("send_dat", mR.tdata, c);
        tick();
        chk("wait_flags", {29'd0, mR.tvalid, mS.tvalid, BUSY}, 32'd1);
    endtask

    task automatic ring_beat(input logic [31:0] d);
        sR.tvalid = 1'b1;
        sR.tdata  = d;
        tick();
        sR.tvalid = 1'b0;
        sR.tdata  = 32'd0;
    endtask

    // With mS.tready high, check the status word and let it drain back to IDLE.
    task automatic take_status(input string tag, input logic [31:0] exp);
        chk({tag, "_vld"}, 32'(mS.tvalid), 32'd1);
        chk({tag, "_dat"}, mS.tdata, exp);
        tick();
        exp_status++;
        chk({tag, "_cnt"}, 32'(n_status), 32'(exp_status));
        chk({tag, "_idle"}, {30'd0, BUSY, sH.tready}, 32'd1);
    endtask

    initial begin
        ARESETN   = 1'b0;
        sH.tvalid = 1'b0;
        sH.tdata  = 32'd0;
        mR.tready = 1'b1;
        sR.tvalid = 1'b0;
        sR.tdata  = 32'd0;
        mS.tready = 1'b1;

        // Reset values
        #12;
        chk("rst_sh_rdy", 32'(sH.tready), 32'd1);
        chk("rst_flags", {28'd0, mR.tvalid, mS.tvalid, BUSY, sR.tready}, 32'd0);
        chk("rst_mr_dat", mR.tdata, 32'd0);
        chk("rst_ms_dat", mS.tdata, 32'd0);
        chk("rst_stale", 32'(STALE_CNT), 32'd0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        #1;
        chk("run_sr_rdy", 32'(sR.tready), 32'd1);
        tick();

        // 1: OK after 5 idle WAIT cycles
        enter_wait(32'h0000_0213);
        repeat (5) tick();
        ring_beat(32'h0000_0002);
        take_status("t1_ok", 32'h0213_0005);

        // 2: NOKEY in the first WAIT cycle, which is the minimum 4-cycle command
        enter_wait(32'h0000_0513);
        ring_beat(32'h0000_0513);
        take_status("t2_nokey", 32'h4513_0000);

        // BADRESP after 2 WAIT cycles
        enter_wait(32'h0000_00A7);
        repeat (2) tick();
        ring_beat(32'h0000_DEAD);
        take_status("tb_bad", 32'h80A7_0002);

        // 3: timeout after 16 WAIT cycles, then a late beat in IDLE
        enter_wait(32'h0000_0100);
        repeat (15) tick();
        chk("t3_still_wait", {30'd0, BUSY, mS.tvalid}, 32'd2);
        tick();
        take_status("t3_to", 32'hC100_0010);
        ring_beat(32'h0000_0001);
        chk("t3_stale", 32'(STALE_CNT), 32'd1);
        chk("t3_no_status", 32'(n_status), 32'(exp_status));
        chk("t3_idle", 32'(BUSY), 32'd0);

        // 5: a response on the last count wins over the timeout
        enter_wait(32'h0000_0300);
        repeat (15) tick();
        ring_beat(32'h0000_0003);
        take_status("t5_edge", 32'h0300_000F);

        // 4: egress stall and status stall
        mR.tready = 1'b0;
        sH.tvalid = 1'b1;
        sH.tdata  = 32'h0000_0213;
        tick();
        sH.tvalid = 1'b0;
        sH.tdata  = 32'd0;
        for (int i = 0; i < 10; i++) begin
            chk("t4_mr_vld", 32'(mR.tvalid), 32'd1);
            chk("t4_mr_dat", mR.tdata, 32'h0000_0213);
            chk("t4_sh_rdy", 32'(sH.tready), 32'd0);
            tick();
        end
        mR.tready = 1'b1;
        tick();
        mS.tready = 1'b0;
        ring_beat(32'h0000_0002);
        for (int i = 0; i < 7; i++) begin
            chk("t4_ms_vld", 32'(mS.tvalid), 32'd1);
            chk("t4_ms_dat", mS.tdata, 32'h0213_0000);
            chk("t4_sh_rdy2", 32'(sH.tready), 32'd0);
            tick();
        end
        chk("t4_held", 32'(n_status), 32'(exp_status));
        mS.tready = 1'b1;
        take_status("t4_done", 32'h0213_0000);
        chk("t4_stale", 32'(STALE_CNT), 32'd1);

        // 6: reset during WAIT aborts the command
        enter_wait(32'h0000_0213);
        repeat (2) tick();
        ARESETN = 1'b0;
        #1;
        chk("t6_flags", {28'd0, mR.tvalid, mS.tvalid, BUSY, sR.tready}, 32'd0);
        chk("t6_sh_rdy", 32'(sH.tready), 32'd1);
        chk("t6_ms_dat", mS.tdata, 32'd0);
        chk("t6_stale", 32'(STALE_CNT), 32'd0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        tick();
        chk("t6_no_status", 32'(n_status), 32'(exp_status));
        enter_wait(32'h0000_0513);
        ring_beat(32'h0000_0513);
        take_status("t6_after", 32'h4513_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
